pipe_collect: RTL

Downstream collection stage for the 5-bit arithmetic pipeline that computes s = ((a+b)−(c+d)) & e with fixed two-cycle latency. It tracks which issue cycles carried valid operands, captures the matching results into a small FIFO, and presents them on a ready/valid output. Credit-based throttling (`in_ready`) guarantees no result is ever dropped, even though the pipeline itself cannot stall. It sits between the operand source and the result consumer, wrapping the pipeline's output side.

---
 rtl/pipe_pkg.sv | 5 +
 rtl/pipe_fifo.sv | 54 +++++
 rtl/pipe_collect.sv | 61 ++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the 5-bit arithmetic pipeline and its collection stage.
package pipe_pkg;
    localparam int PIPE_W   = 5;
    localparam int PIPE_LAT = 2;
endpackage

// File: rtl/pipe_fifo.sv
// Synchronous circular-buffer FIFO; DEPTH need not be a power of two.
module pipe_fifo
    import pipe_pkg::*;
#(
    parameter int W     = PIPE_W,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          overflow
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          full, empty, do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign rdata    = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= next_ptr(wptr);
            if (do_pop)  rptr <= next_ptr(rptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/pipe_collect.sv
// Collects fixed-latency pipeline results into a FIFO, throttling issue by credits.
module pipe_collect
    import pipe_pkg::*;
#(
    parameter int W     = PIPE_W,
    parameter int DEPTH = 4,
    parameter int LAT   = PIPE_LAT,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  s_in,
    output logic          out_valid,
    output logic [W-1:0]  out_data,
    input  logic          out_ready,
    output logic [CW-1:0] count,
    output logic [15:0]   total,
    output logic          err
);
    logic [LAT-1:0] vpipe;
    logic           issue, push, pop, overflow;
    int             inflight;

    // Credits come from registered state only, so a same-cycle pop frees nothing.
    always_comb begin
        inflight = 0;
        for (int k = 0; k < LAT; k++) inflight += int'(vpipe[k]);
    end

    assign in_ready  = (int'(count) + inflight) < DEPTH;
    assign issue     = in_valid && in_ready;
    assign push      = vpipe[LAT-1];
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe <= '0;
            total <= '0;
            err   <= 1'b0;
        end else begin
            vpipe[0] <= issue;
            for (int k = 1; k < LAT; k++) vpipe[k] <= vpipe[k-1];
            if (pop)      total <= total + 16'd1;
            if (overflow) err   <= 1'b1;
        end
    end

    pipe_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .wdata    (s_in),
        .rdata    (out_data),
        .count    (count),
        .overflow (overflow)
    );
endmodule
